sap_ram_seq: RTL and testbench

//  Synchronous, parametrised successor to the SAP main-memory RAM; sits between the MAR/bus and the control unit.
//  - Write port: bus write.
//  - Read port: registered read with a valid strobe.
//  - Post-reset clear sweep.
//  - Auto-incrementing program-load port, so a program is streamed in before the CPU runs.

---
 rtl/sap_ram_seq.sv | 109 ++++++++++
 tb/tb_sap_ram_seq.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sap_ram_seq.sv
// sap_ram_seq: SAP main memory with post-reset clear sweep, streamed program load and registered reads; define RAM_PARITY_EN for per-word parity.
module sap_ram_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ram_write,
  input  logic              ram_read,
  output logic [DATA_W-1:0] ram_out,
  output logic              ram_out_valid,
  input  logic              prog_en,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_valid,
  output logic              prog_ready,
  output logic              prog_done,
  output logic              busy,
  output logic              parity_err
);
  typedef enum logic [1:0] {CLEAR, RUN, PROG} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d, prog_ptr_q, prog_ptr_d;
  logic [DATA_W-1:0] ram_out_q, ram_out_d;
  logic vld_q, vld_d, done_q, done_d, perr_q, perr_d;
  logic we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef RAM_PARITY_EN
  logic mem_par [DEPTH];
`endif
  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    prog_ptr_d = prog_ptr_q;
    ram_out_d  = ram_out_q;
    vld_d      = 1'b0;
    done_d     = 1'b0;
    perr_d     = perr_q;
    we         = 1'b0;
    wa         = addr;
    wd         = bus_in;
    if (state_q == CLEAR) begin
      we        = 1'b1;
      wa        = clr_ptr_q;
      wd        = '0;
      clr_ptr_d = clr_ptr_q + 1'b1;
      state_d   = clr_ptr_q == LAST ? RUN : CLEAR;
    end else if (state_q == PROG) begin
      we         = prog_valid;
      wa         = prog_ptr_q;
      wd         = prog_data;
      prog_ptr_d = prog_valid ? prog_ptr_q + 1'b1 : prog_ptr_q;
      done_d     = prog_valid && prog_ptr_q == LAST;
      state_d    = (done_d || !prog_en) ? RUN : PROG;
    end else if (prog_en) begin
      state_d    = PROG;
      prog_ptr_d = '0;
    end else begin
      we = ram_write;
      if (ram_read) begin
        ram_out_d = mem[addr];
        vld_d     = 1'b1;
`ifdef RAM_PARITY_EN
        perr_d    = (^mem[addr]) ^ mem_par[addr];
`else
        perr_d    = 1'b0;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= '0;
      prog_ptr_q <= '0;
      ram_out_q  <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      prog_ptr_q <= prog_ptr_d;
      ram_out_q  <= ram_out_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      perr_q     <= perr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we && rst_n) begin
      mem[wa]     <= wd;
`ifdef RAM_PARITY_EN
      mem_par[wa] <= ^wd;
`endif
    end
  end
  assign ram_out       = ram_out_q;
  assign ram_out_valid = vld_q;
  assign prog_done     = done_q;
  assign parity_err    = perr_q;
  assign prog_ready    = state_q == PROG;
  assign busy          = state_q != RUN;
endmodule

// File: tb/tb_sap_ram_seq.sv
// tb_sap_ram_seq: scoreboard bench for sap_ram_seq covering clear, read/write, program load, abort and parity.
module tb_sap_ram_seq;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] bus_in = '0, prog_data = '0, ram_out;
  logic [3:0] addr = '0;
  logic ram_write = 1'b0, ram_read = 1'b0, prog_en = 1'b0, prog_valid = 1'b0;
  logic ram_out_valid, prog_ready, prog_done, busy, parity_err;
  typedef struct packed {logic [15:0] d; logic p;} exp_t;
  exp_t sb[$];
  logic [15:0] exp_mem [16];
  logic exp_par [16];
  int n_checks = 0, n_fail = 0;
  sap_ram_seq dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .addr(addr), .ram_write(ram_write),
    .ram_read(ram_read), .ram_out(ram_out), .ram_out_valid(ram_out_valid), .prog_en(prog_en),
    .prog_data(prog_data), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_done(prog_done), .busy(busy), .parity_err(parity_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && ram_out_valid) begin
      if (sb.size() == 0) check("spurious_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("ram_out", {16'd0, ram_out}, {16'd0, e.d});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.p});
      end
    end
  end
  task automatic idle();
    ram_write = 1'b0; ram_read = 1'b0; prog_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    addr = 4'(a); bus_in = d; ram_write = 1'b1; ram_read = 1'b0;
    exp_mem[a] = d; exp_par[a] = 1'b0;
    @(negedge clk);
  endtask
  task automatic rd(input int a);
    addr = 4'(a); ram_read = 1'b1; ram_write = 1'b0;
    sb.push_back('{exp_mem[a], exp_par[a]});
    @(negedge clk);
  endtask
  task automatic rw(input int a, input logic [15:0] d);
    addr = 4'(a); bus_in = d; ram_read = 1'b1; ram_write = 1'b1;
    sb.push_back('{exp_mem[a], exp_par[a]});
    exp_mem[a] = d; exp_par[a] = 1'b0;
    @(negedge clk);
  endtask
  task automatic readback_all();
    for (int a = 0; a < 16; a++) begin rd(a); idle(); end
  endtask
  task automatic wait_clear(input string tag);
    int c = 0;
    while (busy && c < 100) begin c++; @(negedge clk); end
    check(tag, c, 16);
    for (int a = 0; a < 16; a++) begin exp_mem[a] = '0; exp_par[a] = 1'b0; end
  endtask
  task automatic prog_enter();
    prog_en = 1'b1; ram_write = 1'b1; ram_read = 1'b1; addr = '0; bus_in = 16'hDEAD;
    @(negedge clk);
    check("prog_ready", {31'd0, prog_ready}, 32'd1);
    check("prog_busy", {31'd0, busy}, 32'd1);
  endtask
  task automatic prog_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      if (i % 3 == 1) begin prog_valid = 1'b0; @(negedge clk); end
      prog_valid = 1'b1; prog_data = 16'(base + i);
      if (i == 15) begin prog_en = 1'b0; ram_write = 1'b0; ram_read = 1'b0; end
      @(negedge clk);
      exp_mem[i] = 16'(base + i); exp_par[i] = 1'b0;
      check("prog_done", {31'd0, prog_done}, {31'd0, i == 15});
    end
    prog_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ram_out", {16'd0, ram_out}, 32'd0);
    check("rst_valid", {31'd0, ram_out_valid}, 32'd0);
    check("rst_prog_ready", {31'd0, prog_ready}, 32'd0);
    check("rst_prog_done", {31'd0, prog_done}, 32'd0);
    check("rst_parity", {31'd0, parity_err}, 32'd0);
    rst_n = 1'b1;
    ram_write = 1'b1; ram_read = 1'b1; addr = 4'd7; bus_in = 16'hFFFF;
    wait_clear("clear_len");
    idle();
    readback_all();
    wr(2, 16'h0009); rd(2); idle();
    wr(5, 16'h1234); idle();
    rw(5, 16'hBEEF); rd(5); idle();
    prog_enter();
    prog_words(16, 16'h0100);
    check("load_busy", {31'd0, busy}, 32'd0);
    idle();
    check("done_pulse", {31'd0, prog_done}, 32'd0);
    readback_all();
    prog_enter();
    prog_words(6, 16'h0A00);
    prog_en = 1'b0; ram_write = 1'b0; ram_read = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, prog_done}, 32'd0);
    readback_all();
    prog_enter();
    prog_words(3, 16'h0C00);
    rst_n = 1'b0; prog_valid = 1'b1;
    @(negedge clk);
    check("midload_rst_busy", {31'd0, busy}, 32'd1);
    check("midload_rst_ready", {31'd0, prog_ready}, 32'd0);
    check("midload_rst_out", {16'd0, ram_out}, 32'd0);
    rst_n = 1'b1; prog_en = 1'b0; prog_valid = 1'b0; ram_write = 1'b0; ram_read = 1'b0;
    wait_clear("reclear_len");
    readback_all();
    wr(2, 16'h0002); wr(3, 16'h00FF); idle();
`ifdef RAM_PARITY_EN
    dut.mem_par[3] = ~dut.mem_par[3];
    exp_par[3] = 1'b1;
`endif
    rd(3); idle(); rd(2); idle();
    repeat (3) idle();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
